// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit counter width: indexes 0..w-1, never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between the ALU datapath and the serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 4) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;

  modport master (output start, A, B, Bin, input busy, done, D, Bout);
  modport slave  (input start, A, B, Bin, output busy, done, D, Bout);
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, reused every cycle by the serial datapath.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - Bin, LSB first, one bit per clock behind start/done.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_subtractor_if.slave   bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_res, r_D;
  logic             r_borrow, r_Bout;

  logic w_accept, w_last, w_d, w_bout;

  // start only counts when no operation is in flight
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CW'(WIDTH - 1));

  full_subtractor u_fs (
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .Bin  (r_borrow),
    .D    (w_d),
    .Bout (w_bout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: DONE doubles as an accept slot for back-to-back operations
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_accept ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_state_nxt = w_last   ? ST_DONE  : ST_SHIFT;
      ST_DONE:  w_state_nxt = w_accept ? ST_SHIFT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift one bit per SHIFT cycle,
  // publish D/Bout only on the completing edge so they hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_D      <= '0;
      r_Bout   <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_a_sh   <= bus.A;
      r_b_sh   <= bus.B;
      r_borrow <= bus.Bin;
    end else if (r_state == ST_SHIFT) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res    <= {w_d, r_res[WIDTH-1:1]};
      r_borrow <= w_bout;
      r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_D    <= {w_d, r_res[WIDTH-1:1]};
        r_Bout <= w_bout;
      end
    end
  end

  assign bus.busy = (r_state == ST_SHIFT);
  assign bus.done = (r_state == ST_DONE);
  assign bus.D    = r_D;
  assign bus.Bout = r_Bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + exhaustive checks of the serial subtractor at WIDTH=4.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    bus.start = s;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bi;
  endtask

  // Accept one op then wait (bounded) for done; reports latency in edges.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        output int lat);
    drive(1'b1, a, b, bi);
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < W + 3) begin
      tick();
      lat++;
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    logic [W:0] ref_v;

    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_D",    bus.D,    0);
    chk("rst_Bout", bus.Bout, 0);
    reset = 1'b0;
    tick();

    // Basic: 7 - 2, busy for exactly 4 cycles then done
    drive(1'b1, 4'b0111, 4'b0010, 1'b0);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("basic_busy", bus.busy, 1);
      chk("basic_nodone", bus.done, 0);
      tick();
    end
    chk("basic_busy4", bus.busy, 1);
    tick();
    chk("basic_done", bus.done, 1);
    chk("basic_busy_lo", bus.busy, 0);
    chk("basic_D", bus.D, 4'b0101);
    chk("basic_Bout", bus.Bout, 0);
    tick();
    chk("basic_done_1cyc", bus.done, 0);

    // Underflow and borrow-in
    run_op(4'b0010, 4'b0111, 1'b0, lat);
    chk("uf_lat", lat, 4);
    chk("uf_D", bus.D, 4'b1011);
    chk("uf_Bout", bus.Bout, 1);
    run_op(4'b0000, 4'b0000, 1'b1, lat);
    chk("bin_D", bus.D, 4'b1111);
    chk("bin_Bout", bus.Bout, 1);
    run_op(4'b1111, 4'b1111, 1'b0, lat);
    chk("eq_D", bus.D, 4'b0000);
    chk("eq_Bout", bus.Bout, 0);
    tick();

    // Start during busy is ignored
    drive(1'b1, 4'b0111, 4'b0010, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    drive(1'b1, 4'b0001, 4'b0001, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    chk("ign_nodone", bus.done, 0);
    tick();
    chk("ign_done", bus.done, 1);
    chk("ign_D", bus.D, 4'b0101);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ign_no_extra", bus.done, 0);
    end
    chk("ign_idle_busy", bus.busy, 0);

    // Back-to-back through the DONE cycle
    drive(1'b1, 4'b0111, 4'b0010, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    drive(1'b1, 4'b1000, 4'b0001, 1'b0);
    tick();
    chk("b2b_done1", bus.done, 1);
    chk("b2b_D1", bus.D, 4'b0101);
    tick();
    bus.start = 1'b0;
    chk("b2b_accept_busy", bus.busy, 1);
    chk("b2b_accept_done", bus.done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b_hold_D", bus.D, 4'b0101);
      chk("b2b_nodone", bus.done, 0);
    end
    tick();
    chk("b2b_done2", bus.done, 1);
    chk("b2b_D2", bus.D, 4'b0111);
    chk("b2b_Bout2", bus.Bout, 0);

    // Reset mid-operation
    drive(1'b1, 4'b0010, 4'b0111, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_D", bus.D, 0);
    chk("mrst_Bout", bus.Bout, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_no_done", bus.done, 0);
    end
    run_op(4'b1001, 4'b0011, 1'b1, lat);
    chk("mrst_fresh_lat", lat, 4);
    chk("mrst_fresh_D", bus.D, 4'b0101);
    chk("mrst_fresh_Bout", bus.Bout, 0);

    // Exhaustive against an unsigned (W+1)-bit reference
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          ref_v = {1'b0, 4'(a)} - {1'b0, 4'(b)} - {4'b0, 1'(c)};
          run_op(4'(a), 4'(b), 1'(c), lat);
          chk("exh_D", bus.D, ref_v[W-1:0]);
          chk("exh_Bout", bus.Bout, ref_v[W]);
        end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
